// File: rtl/data_memory_mmio_pkg.sv
// Shared constants for the data memory: MMIO register offsets, STATUS bit layout and default MMIO base.
// Also holds the saturating count helper used to build the STATUS read value.
package data_memory_mmio_pkg;

   localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

   localparam logic [31:0] OFS_TXDATA = 32'h0000_0000;
   localparam logic [31:0] OFS_STATUS = 32'h0000_0004;
   localparam logic [31:0] OFS_CYCLES = 32'h0000_0008;

   localparam int ST_EMPTY   = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_OVF     = 2;
   localparam int ST_CNT_LSB = 4;

   // STATUS has a 4-bit count field; deeper FIFOs show 15 once they reach it.
   function automatic logic [3:0] sat_count4(input logic [31:0] cnt);
      if (cnt > 32'd15) begin
         return 4'hF;
      end
      return cnt[3:0];
   endfunction

endpackage

// File: rtl/data_memory_mmio_tx_fifo.sv
// DEPTH x 8 synchronous FIFO for the transmit path. A push into a full FIFO is taken only
// when a pop frees a slot in the same cycle; the overflow policy lives in the parent.
module tx_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [7:0]                 push_data,
   input  logic                       pop,
   output logic [7:0]                 head,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage is cleared on reset so the head byte reads 0 until the first push.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
         end
      end
   end

endmodule

// File: rtl/data_memory_mmio.sv
// Data-side memory for the single-cycle core: word RAM below MMIO_BASE, and above it a
// transmit FIFO (TXDATA/STATUS) plus a free-running CYCLES counter. readdata is combinational.
module data_memory_mmio
   import data_memory_mmio_pkg::*;
#(
   parameter int          MEM_WORDS  = 1024,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] addr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int IW = $clog2(MEM_WORDS);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]   ram_q [MEM_WORDS];
   logic [IW-1:0] ram_idx;
   logic          is_mmio;
   logic [31:0]   mmio_ofs;
   logic          sel_ram, sel_tx, sel_status, sel_cycles;
   logic          wr_en;

   logic          ovf_q, ovf_d;
   logic [31:0]   cycles_q, cycles_d;
   logic [31:0]   status_word;

   logic          fifo_push;
   logic          fifo_empty, fifo_full;
   logic [7:0]    fifo_head;
   logic [CW-1:0] fifo_count;

   assign is_mmio    = (addr >= MMIO_BASE);
   assign mmio_ofs   = addr - MMIO_BASE;
   assign sel_ram    = !is_mmio;
   assign sel_tx     = is_mmio && (mmio_ofs == OFS_TXDATA);
   assign sel_status = is_mmio && (mmio_ofs == OFS_STATUS);
   assign sel_cycles = is_mmio && (mmio_ofs == OFS_CYCLES);
   assign ram_idx    = addr[IW+1:2];
   assign wr_en      = memwrite && !reset;
   assign fifo_push  = wr_en && sel_tx;

   tx_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_tx_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (fifo_push),
      .push_data(writedata[7:0]),
      .pop      (tx_ready),
      .head     (fifo_head),
      .empty    (fifo_empty),
      .full     (fifo_full),
      .count    (fifo_count)
   );

   assign tx_valid = !fifo_empty;
   assign tx_data  = fifo_head;

   // A full FIFO still accepts a push when the consumer drains the head in the same cycle.
   always_comb begin
      ovf_d = ovf_q;
      if (fifo_push && fifo_full && !tx_ready) begin
         ovf_d = 1'b1;
      end else if (wr_en && sel_status && writedata[ST_OVF]) begin
         ovf_d = 1'b0;
      end
   end

   always_comb begin
      cycles_d = cycles_q + 32'd1;
      if (wr_en && sel_cycles) begin
         cycles_d = writedata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_q    <= 1'b0;
         cycles_q <= 32'h0000_0000;
      end else begin
         ovf_q    <= ovf_d;
         cycles_q <= cycles_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && sel_ram) begin
         ram_q[ram_idx] <= writedata;
      end
   end

   always_comb begin
      status_word                           = 32'h0000_0000;
      status_word[ST_EMPTY]                 = fifo_empty;
      status_word[ST_FULL]                  = fifo_full;
      status_word[ST_OVF]                   = ovf_q;
      status_word[ST_CNT_LSB+3:ST_CNT_LSB]  = sat_count4(32'(fifo_count));
   end

   always_comb begin
      readdata = 32'h0000_0000;
      if (sel_ram) begin
         readdata = ram_q[ram_idx];
      end else if (sel_status) begin
         readdata = status_word;
      end else if (sel_cycles) begin
         readdata = cycles_q;
      end
   end

endmodule

// File: tb/tb_data_memory_mmio.sv
// Bench for data_memory_mmio: table-driven RAM/decode vectors, hand-written FIFO, CYCLES and
// async-reset sequences, and a byte scoreboard checked whenever the drain port pops.
module tb_data_memory_mmio;

   localparam logic [31:0] A_TX  = 32'hFFFF_0000;
   localparam logic [31:0] A_ST  = 32'hFFFF_0004;
   localparam logic [31:0] A_CYC = 32'hFFFF_0008;

   logic        clk = 1'b0;
   logic        reset;
   logic        memwrite;
   logic [31:0] addr;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   int checks   = 0;
   int failures = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic        we;
      logic [31:0] a;
      logic [31:0] d;
      logic        chk;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[18];

   data_memory_mmio dut (
      .clk      (clk),
      .reset    (reset),
      .memwrite (memwrite),
      .addr     (addr),
      .writedata(writedata),
      .readdata (readdata),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready)
   );

   // clock/reset: posedges at 5,15,...; inputs change on negedges
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rdy);
      @(negedge clk);
      memwrite  = we;
      addr      = a;
      writedata = d;
      tx_ready  = rdy;
      #1;
   endtask

   // scoreboard: every pop the DUT is about to perform must match the oldest expected byte
   always @(negedge clk) begin
      #3;
      if (!reset && tx_valid && tx_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL tx_pop: got 0x%02h expected no byte", tx_data);
         end else begin
            check("tx_pop", 32'(tx_data), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected TB_RESULT");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{1'b1, 32'h0000_0010, 32'h1111_1111, 1'b0, 32'h0};
      vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'h1111_1111};
      vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};
      vecs[3]  = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF};
      vecs[4]  = '{1'b0, 32'h0000_1010, 32'h0,         1'b1, 32'hDEAD_BEEF};
      vecs[5]  = '{1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1'b0, 32'h0};
      vecs[6]  = '{1'b0, 32'h0000_0020, 32'h0,         1'b1, 32'hCAFE_F00D};
      vecs[7]  = '{1'b1, 32'hFFFE_FFFC, 32'hA5A5_5A5A, 1'b0, 32'h0};
      vecs[8]  = '{1'b0, 32'h0000_0FFC, 32'h0,         1'b1, 32'hA5A5_5A5A};
      vecs[9]  = '{1'b1, 32'h0000_000C, 32'h0000_0000, 1'b0, 32'h0};
      vecs[10] = '{1'b0, 32'hFFFF_000C, 32'h0,         1'b1, 32'h0};
      vecs[11] = '{1'b1, 32'hFFFF_000C, 32'h1234_5678, 1'b1, 32'h0};
      vecs[12] = '{1'b0, 32'hFFFF_000C, 32'h0,         1'b1, 32'h0};
      vecs[13] = '{1'b0, 32'h0000_000C, 32'h0,         1'b1, 32'h0};
      vecs[14] = '{1'b0, 32'hFFFF_0000, 32'h0,         1'b1, 32'h0};
      vecs[15] = '{1'b0, 32'hFFFF_0004, 32'h0,         1'b1, 32'h0000_0001};
      vecs[16] = '{1'b0, 32'hFFFF_0010, 32'h0,         1'b1, 32'h0};
      vecs[17] = '{1'b0, 32'h0000_1FFC, 32'h0,         1'b1, 32'hA5A5_5A5A};

      reset     = 1'b1;
      memwrite  = 1'b0;
      addr      = A_ST;
      writedata = 32'h0;
      tx_ready  = 1'b0;

      @(negedge clk);
      #1;
      check("rst_tx_valid", 32'(tx_valid), 32'h0);
      check("rst_tx_data", 32'(tx_data), 32'h0);
      check("rst_status", readdata, 32'h0000_0001);
      addr = A_CYC;
      #1;
      check("rst_cycles", readdata, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 18; i++) begin
         cyc(vecs[i].we, vecs[i].a, vecs[i].d, 1'b0);
         if (vecs[i].chk) begin
            check($sformatf("vec%0d", i), readdata, vecs[i].exp);
         end
      end

      // fill to full, overflow on the ninth byte, drain, clear overflow
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, A_TX, 32'(8'h41 + i), 1'b0);
         exp_q.push_back(8'(8'h41 + i));
      end
      cyc(1'b0, A_ST, 32'h0, 1'b0);
      check("fill_status", readdata, 32'h0000_0082);
      cyc(1'b1, A_TX, 32'h49, 1'b0);
      cyc(1'b0, A_ST, 32'h0, 1'b0);
      check("ovf_status", readdata, 32'h0000_0086);
      check("ovf_head", 32'(tx_data), 32'h41);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, A_ST, 32'h0, 1'b1);
         check($sformatf("drain_valid%0d", i), 32'(tx_valid), 32'h1);
      end
      cyc(1'b0, A_ST, 32'h0, 1'b1);
      check("drained_status", readdata, 32'h0000_0005);
      check("drained_valid", 32'(tx_valid), 32'h0);
      cyc(1'b1, A_ST, 32'h4, 1'b0);
      cyc(1'b0, A_ST, 32'h0, 1'b0);
      check("ovf_clear", readdata, 32'h0000_0001);

      // push into a full FIFO while the head is popped
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, A_TX, 32'(8'h61 + i), 1'b0);
         exp_q.push_back(8'(8'h61 + i));
      end
      cyc(1'b0, A_ST, 32'h0, 1'b0);
      check("full2_status", readdata, 32'h0000_0082);
      cyc(1'b1, A_TX, 32'h55, 1'b1);
      exp_q.push_back(8'h55);
      cyc(1'b0, A_ST, 32'h0, 1'b0);
      check("pushpop_status", readdata, 32'h0000_0082);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, A_ST, 32'h0, 1'b1);
      end
      cyc(1'b0, A_ST, 32'h0, 1'b0);
      check("pushpop_drained", readdata, 32'h0000_0001);

      // push into an empty FIFO with the consumer ready: no bypass
      cyc(1'b1, A_TX, 32'h7A, 1'b1);
      check("empty_push_valid", 32'(tx_valid), 32'h0);
      exp_q.push_back(8'h7A);
      cyc(1'b0, A_ST, 32'h0, 1'b1);
      check("empty_push_next_valid", 32'(tx_valid), 32'h1);
      check("empty_push_next_data", 32'(tx_data), 32'h7A);
      check("empty_push_status", readdata, 32'h0000_0010);
      cyc(1'b0, A_ST, 32'h0, 1'b1);
      check("empty_push_gone", 32'(tx_valid), 32'h0);
      check("empty_push_status2", readdata, 32'h0000_0001);

      // CYCLES counts edges since reset release, then load and wrap
      @(negedge clk);
      reset    = 1'b1;
      memwrite = 1'b0;
      tx_ready = 1'b0;
      addr     = A_CYC;
      #1;
      check("cyc_in_reset", readdata, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("cyc0", readdata, 32'h0);
      for (int k = 1; k <= 3; k++) begin
         cyc(1'b0, A_CYC, 32'h0, 1'b0);
         check($sformatf("cyc%0d", k), readdata, 32'(k));
      end
      cyc(1'b1, A_CYC, 32'hFFFF_FFFE, 1'b0);
      check("cyc_pre_load", readdata, 32'd4);
      cyc(1'b0, A_CYC, 32'h0, 1'b0);
      check("cyc_load", readdata, 32'hFFFF_FFFE);
      cyc(1'b0, A_CYC, 32'h0, 1'b0);
      check("cyc_max", readdata, 32'hFFFF_FFFF);
      cyc(1'b0, A_CYC, 32'h0, 1'b0);
      check("cyc_wrap", readdata, 32'h0);
      cyc(1'b0, A_CYC, 32'h0, 1'b0);
      check("cyc_after_wrap", readdata, 32'h1);

      // asynchronous reset with bytes queued
      cyc(1'b1, A_CYC, 32'd97, 1'b0);
      cyc(1'b1, 32'h0000_0040, 32'h0BAD_F00D, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, A_TX, 32'(8'h31 + i), 1'b0);
         exp_q.push_back(8'(8'h31 + i));
      end
      cyc(1'b0, A_ST, 32'h0, 1'b0);
      check("q3_status", readdata, 32'h0000_0030);
      cyc(1'b0, A_CYC, 32'h0, 1'b0);
      check("q3_cycles", readdata, 32'd102);
      #1;
      reset = 1'b1;
      exp_q.delete();
      #1;
      check("arst_valid", 32'(tx_valid), 32'h0);
      check("arst_data", 32'(tx_data), 32'h0);
      check("arst_cycles", readdata, 32'h0);
      addr = A_ST;
      #1;
      check("arst_status", readdata, 32'h0000_0001);
      addr      = 32'h0000_0040;
      memwrite  = 1'b1;
      writedata = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      check("arst_ram_write_ignored", readdata, 32'h0BAD_F00D);
      @(negedge clk);
      reset    = 1'b0;
      memwrite = 1'b0;
      #1;
      check("post_rst_ram", readdata, 32'h0BAD_F00D);
      cyc(1'b0, A_ST, 32'h0, 1'b1);
      check("post_rst_status", readdata, 32'h0000_0001);
      check("post_rst_valid", 32'(tx_valid), 32'h0);

      check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/data_memory_mmio.md
Name: data_memory_mmio

Overview:
Data-side memory for the single-cycle MIPS core. It sits directly downstream of the core's data port and consumes memwrite, aluout (as the address) and writedata. It returns readdata in the same cycle.
- Word RAM below MMIO_BASE.
- Above MMIO_BASE: a memory-mapped byte transmit FIFO with a valid/ready drain port, plus a free-running cycle counter, so programs can emit output and measure time.

Parameters:
MEM_WORDS, 1024, number of 32-bit RAM words; power of two.
FIFO_DEPTH, 8, transmit FIFO entries; power of two, at least 2.
MMIO_BASE, 32'hFFFF_0000, first MMIO byte address; addresses at or above it are MMIO.

Ports:
clk  input  1  core clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset
memwrite  input  1  write strobe from core, sampled at rising clk
addr  input  32  byte address (core aluout)
writedata  input  32  store data from core
readdata  output  32  load data; combinational from addr and current state
tx_data  output  8  FIFO head byte
tx_valid  output  1  FIFO non-empty
tx_ready  input  1  consumer accepts head byte this cycle

Behaviour:
- Decode
  - addr < MMIO_BASE selects RAM.
  - Word index is addr[log2(MEM_WORDS)+1:2]. addr[1:0] is ignored, and higher bits alias (wrap modulo RAM size).
  - MMIO registers decode on addr - MMIO_BASE, which must be exactly one of 0x0, 0x4 or 0x8. Any other MMIO address reads 0 and ignores writes.
- RAM
  - Read is asynchronous.
  - Write at rising clk when memwrite=1 and RAM is selected.
  - Contents are not affected by reset.
  - A read of the address being written in the same cycle returns the old word.
- TXDATA (0x0)
  - Write, not full: pushes writedata[7:0].
  - Write, full: byte dropped and overflow set (sticky).
  - Read returns 0.
- STATUS (0x4)
  - Read fields: bit0 empty; bit1 full; bit2 overflow; bits[7:4] count (zero-extended, saturating display at 15); other bits 0.
  - Write with writedata[2]=1 clears overflow. Other bits are ignored.
- CYCLES (0x8)
  - 32-bit counter, +1 every clk, wraps 0xFFFFFFFF to 0.
  - A write loads writedata at that edge; load wins over increment.
  - Read returns the current value.
- FIFO drain
  - tx_valid=!empty; tx_data=entry at read pointer.
  - Pop occurs at rising clk when tx_valid && tx_ready.
  - tx_data may change only after a pop or when going non-empty.
- Simultaneous push and pop
  - Both take effect, so count is unchanged.
  - When full, the pop frees the slot, so the push is accepted and overflow is not set.
  - When empty, the push is accepted and no pop occurs, because tx_valid=0. There is no bypass: the byte appears with tx_valid=1 on the next cycle.
- Overflow priority: a set (a dropped push) and a clear (a STATUS write) cannot coincide, since one address is written per cycle.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits. full = count==FIFO_DEPTH; empty = count==0.
- STATUS and CYCLES reads reflect pre-edge state; effects of the current cycle's write are visible next cycle.
- Reset (asynchronous, any time): FIFO pointers and count = 0, overflow = 0, CYCLES = 0.
  - Output reset values: tx_valid=0, tx_data=0.
  - readdata follows addr: RAM contents for RAM addresses, reset register values for MMIO addresses.
  - Reset mid-transfer discards all queued bytes.
  - memwrite is ignored while reset=1.
- No latency beyond one edge for any state update. readdata is purely combinational, as the single-cycle core requires.

Decomposition:
- Shared package holds:
  - MMIO offsets: OFS_TXDATA=0x0, OFS_STATUS=0x4, OFS_CYCLES=0x8.
  - STATUS bit positions: ST_EMPTY=0, ST_FULL=1, ST_OVF=2, ST_CNT_LSB=4.
  - The default MMIO_BASE.
- One sub-module, tx_fifo: parameterised DEPTH×8 synchronous FIFO.
  - Inputs: push, push_data, pop.
  - Outputs: head, empty, full, count.
  - Overflow policy stays in the top-level data_memory_mmio.

Test Plan:
- RAM round trip: store 0xDEADBEEF to 0x0000_0010, then load 0x10 and 0x13 → both read 0xDEADBEEF. Load 0x0000_1010 (alias, MEM_WORDS=1024) → 0xDEADBEEF. Load of the same address during the write cycle → old value.
- FIFO fill/drain with tx_ready=0: push 0x41..0x48 (8 bytes) → STATUS=0x82 (full, count=8). Ninth push 0x49 → STATUS=0x86, byte dropped. Raise tx_ready → bytes 0x41..0x48 out in order, one per cycle, then STATUS=0x05. Write STATUS 0x4 → STATUS=0x01.
- Simultaneous push/pop when full, tx_ready=1: push 0x55 → accepted, overflow stays 0, count stays 8, 0x55 emerges last.
- Empty push: push 0x7A with tx_ready=1 → tx_valid low that cycle, high next cycle with tx_data=0x7A; popped the following edge.
- CYCLES: after reset, read at edge N → N. Write 0xFFFF_FFFE → reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 on successive cycles. Unmapped MMIO 0xFFFF_000C reads 0.
- Async reset mid-operation: with 3 bytes queued and CYCLES≈100, assert reset between edges → tx_valid=0, STATUS=0x01, CYCLES=0 immediately, without waiting for a clock edge. RAM word written before reset is still readable.
